axis_stream_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) AXI-Stream FIFO.
- Sits directly upstream of the AXI-Lite stream reader and decouples a bursty producer (ADC/DSP chain) from slow software polling.
- Exposes fill level, a sticky overflow flag and a threshold flag so software can poll or interrupt before reading.
- The downstream reader samples m_axis_tdata whenever m_axis_tvalid is high. m_axis_tdata therefore always shows the head word while m_axis_tvalid=1.

---
 rtl/axis_fifo_pkg.sv | 24 ++
 rtl/axis_fifo_ram.sv | 32 +++
 rtl/axis_stream_fifo.sv | 111 +++++++++++
 tb/tb_axis_stream_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
//   Shared helpers for the AXI-Stream FIFO slice.
//   - clog2        : ceiling log2 for sizing derived from a word count.
//   - fifo_depth   : number of words for a given pointer width.
//   - count_width  : bits needed to hold 0..DEPTH inclusive.
package axis_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram
//   Simple dual-port storage: synchronous write, asynchronous read, so the
//   head word is visible in the same cycle the read address changes (FWFT).
//   Ports:
//     clk_i    : write clock
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address (combinational read)
//     rdata_o  : read data
//   Contents are never reset.
module axis_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo
//   First-word-fall-through AXI-Stream FIFO between a bursty producer and a
//   slow polled reader. Reports fill level, a sticky overflow flag and a
//   threshold flag.
//   Ports:
//     aclk, aresetn        : clock, synchronous active-low reset
//     s_axis_tdata/tvalid  : producer word / valid
//     s_axis_tready        : FIFO accepts (always 1 out of reset when CONTINUOUS=1)
//     m_axis_tdata/tvalid  : head word / FIFO non-empty
//     m_axis_tready        : consumer pops the head word
//     data_count           : words stored, 0..DEPTH
//     overflow             : sticky, a word was dropped (CONTINUOUS=1 only)
//     clear_overflow       : pulse to clear overflow
//     level_flag           : data_count >= THRESHOLD
//   Handshake: a word moves on a rising edge exactly when valid and ready are
//   both high in the cycle before it; valid never depends on ready. In
//   CONTINUOUS mode tready stays high and a word offered while full is
//   discarded instead of stalled.
module axis_stream_fifo
  import axis_fifo_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int CONTINUOUS      = 0,
  parameter int THRESHOLD       = 512
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [ADDR_WIDTH:0]        data_count,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic                       level_flag
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C     = CW'(fifo_depth(ADDR_WIDTH));
  localparam logic [CW-1:0] THRESHOLD_C = CW'(THRESHOLD);
  localparam logic          CONT        = (CONTINUOUS != 0);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  level_q;

  logic full;
  logic push;
  logic pop;
  logic drop;

  // Full is judged on the start-of-cycle count, so a simultaneous pop does
  // not make room for a word offered to a full FIFO.
  assign full  = (count_q == DEPTH_C);
  assign push  = s_axis_tvalid & ~full & aresetn;
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign drop  = CONT & s_axis_tvalid & full;

  assign s_axis_tready = aresetn & (CONT | ~full);
  assign m_axis_tvalid = (count_q != '0);
  assign data_count    = count_q;
  assign overflow      = overflow_q;
  assign level_flag    = level_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    overflow_d = overflow_q;
    // A drop in the same cycle as a clear wins so no drop goes unreported.
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      // Derived from the next count so it tracks data_count with no lag.
      level_q    <= (count_d >= THRESHOLD_C);
    end
  end

  axis_fifo_ram #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis_tdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo
//   Drives one backpressuring FIFO (CONTINUOUS=0, index 0) and one dropping
//   FIFO (CONTINUOUS=1, index 1) with identical inputs and compares both to a
//   queue-based reference model.
module tb_axis_stream_fifo;

  localparam int W     = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic          aclk;
  logic          aresetn;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          m_tready;
  logic          clr;

  logic          s_tready [2];
  logic [W-1:0]  m_tdata  [2];
  logic          m_tvalid [2];
  logic [AW:0]   dcount   [2];
  logic          ovf      [2];
  logic          level    [2];

  // Reference model state
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic          exp_ovf [2];

  int n_assert;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- DUTs ----------------
  axis_stream_fifo #(
    .AXIS_DATA_WIDTH (W), .ADDR_WIDTH (AW), .CONTINUOUS (0), .THRESHOLD (THR)
  ) u_bp (
    .aclk (aclk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready[0]),
    .m_axis_tdata (m_tdata[0]), .m_axis_tvalid (m_tvalid[0]), .m_axis_tready (m_tready),
    .data_count (dcount[0]), .overflow (ovf[0]), .clear_overflow (clr),
    .level_flag (level[0])
  );

  axis_stream_fifo #(
    .AXIS_DATA_WIDTH (W), .ADDR_WIDTH (AW), .CONTINUOUS (1), .THRESHOLD (THR)
  ) u_ct (
    .aclk (aclk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready[1]),
    .m_axis_tdata (m_tdata[1]), .m_axis_tvalid (m_tvalid[1]), .m_axis_tready (m_tready),
    .data_count (dcount[1]), .overflow (ovf[1]), .clear_overflow (clr),
    .level_flag (level[1])
  );

  // ---------------- model helpers ----------------
  function automatic int msize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] mfront(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  // One clock edge of the abstract FIFO: a word joins the tail if there was
  // room at the start of the cycle; the head leaves if the consumer asked.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  sz;
      bit  do_pop;
      bit  do_push;
      bit  do_drop;
      sz = msize(k);
      if (!aresetn) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        exp_ovf[k] = 1'b0;
      end else begin
        do_pop  = (sz != 0) && m_tready;
        do_push = s_tvalid && (sz < DEPTH);
        do_drop = (k == 1) && s_tvalid && (sz == DEPTH);
        if (do_pop) begin
          if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (do_push) begin
          if (k == 0) exp_q0.push_back(s_tdata); else exp_q1.push_back(s_tdata);
        end
        if (do_drop)  exp_ovf[k] = 1'b1;
        else if (clr) exp_ovf[k] = 1'b0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int k, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d] t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = msize(k);
      chk("tvalid", k, W'(m_tvalid[k]), W'(sz != 0));
      if (sz != 0) chk("tdata", k, m_tdata[k], mfront(k));
      chk("data_count", k, W'(dcount[k]), W'(sz));
      chk("level_flag", k, W'(level[k]), W'(sz >= THR));
      chk("overflow", k, W'(ovf[k]), W'(exp_ovf[k]));
      chk("s_tready", k, W'(s_tready[k]),
          W'(aresetn && ((k == 1) || (sz < DEPTH))));
    end
  endtask

  // Inputs are changed only at #1 after a rising edge, so they are stable when
  // the model samples them right at the next edge.
  task automatic tick();
    @(posedge aclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy,
                       input logic c);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
    clr      = c;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_ovf[0] = 1'b0;
    exp_ovf[1] = 1'b0;
    aresetn  = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset: tready forced low while held.
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    check_all();

    // 1. Single word through, then popped.
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // 2 / 4. Overfill with no pops: backpressure vs drop + overflow.
    for (int v = 1; v <= 6; v++) begin
      drive(1'b1, W'(v), 1'b0, 1'b0);
      tick();
    end
    // 5. Clear in the same cycle as another dropped word: set wins.
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    tick();
    // Clear alone.
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    // Full with push and pop together: push refused / dropped, pop completes.
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    tick();
    // Drain, then accept a word once room exists.
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    tick();

    // 3. Steady push+pop at count 2 across pointer wrap.
    drive(1'b1, 32'hB0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, W'(32'hC0 + i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    // 6. Fill to 3, reset for one edge while pushing 0x77.
    for (int v = 0; v < 3; v++) begin
      drive(1'b1, W'(32'h60 + v), 1'b0, 1'b0);
      tick();
    end
    aresetn = 1'b0;
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    aresetn = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check_all();
    tick();

    // Randomized traffic, biased toward producer so full/drop cases occur.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 199) == 0) aresetn = 1'b0;
      else aresetn = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
